clk_div_n: RTL and testbench

Programmable integer clock divider producing a 50%-duty output for any divisor N ≥ 2, odd or even. Odd divisors are handled with a negative-edge half-cycle stage. The divisor can be reloaded at runtime and takes effect only on a period boundary. Enable and disable are glitch-free. The block sits in the clocking utilities, generating slow peripheral and strobe clocks from the system clock.

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_neg_stage.sv | 23 ++
 rtl/clk_div_n.sv | 126 ++++++++++++
 tb/tb_clk_div_n.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and types for the programmable clock divider
package clk_div_pkg;
  localparam int DIV_MIN       = 2;
  localparam int CNT_W_DEFAULT = 8;

  typedef logic [CNT_W_DEFAULT-1:0] div_t;

  typedef enum logic {
    PARKED  = 1'b0,
    RUNNING = 1'b1
  } run_state_t;
endpackage

// File: rtl/clk_div_neg_stage.sv
// rtl/clk_div_neg_stage.sv - negedge half-cycle flop and odd-mode output OR
module clk_div_neg_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic p,
  input  logic odd,
  output logic clk_out
);

  logic n;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= 1'b0;
    end else begin
      n <= p;
    end
  end

  // n trails p by half a cycle, stretching the high phase for odd divisors
  assign clk_out = odd ? (p | n) : p;

endmodule

// File: rtl/clk_div_n.sv
// rtl/clk_div_n.sv - programmable 50%-duty integer clock divider with glitch-free enable
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int DIV_RST = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_cur,
  output logic             load_err
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(DIV_MIN);

  run_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] div_act, div_act_n;
  logic [CNT_W-1:0] div_pend, div_pend_n;
  logic             pend_v, pend_v_n;
  logic             p, p_n;
  logic             tick_n, load_err_n;
  logic [CNT_W-1:0] div_nxt, cnt_inc, half;
  logic             wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PARKED;
      cnt      <= CNT_W'(DIV_RST - 1);
      div_act  <= CNT_W'(DIV_RST);
      div_pend <= CNT_W'(DIV_RST);
      pend_v   <= 1'b0;
      p        <= 1'b0;
      tick     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      div_act  <= div_act_n;
      div_pend <= div_pend_n;
      pend_v   <= pend_v_n;
      p        <= p_n;
      tick     <= tick_n;
      load_err <= load_err_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    p_n        = p;
    div_act_n  = div_act;
    div_pend_n = div_pend;
    pend_v_n   = pend_v;
    load_err_n = 1'b0;
    div_nxt    = pend_v ? div_pend : div_act;
    cnt_inc    = cnt + ONE;
    half       = div_act >> 1;
    wrap       = (cnt == div_act - ONE);

    case (state)
      PARKED: begin
        div_act_n = div_nxt;
        pend_v_n  = 1'b0;
        if (en) begin
          state_n = RUNNING;
          cnt_n   = '0;
          p_n     = 1'b1;
        end else begin
          cnt_n = div_nxt - ONE;
          p_n   = 1'b0;
        end
      end
      RUNNING: begin
        if (wrap) begin
          // a new period (or parking) always begins with p and n both low
          div_act_n = div_nxt;
          pend_v_n  = 1'b0;
          if (en) begin
            cnt_n = '0;
            p_n   = 1'b1;
          end else begin
            state_n = PARKED;
            cnt_n   = div_nxt - ONE;
            p_n     = 1'b0;
          end
        end else begin
          cnt_n = cnt_inc;
          p_n   = (cnt_inc < half);
        end
      end
      default: begin
        state_n = PARKED;
      end
    endcase

    // a load in the same cycle as an apply stays pending for the next boundary
    if (div_load) begin
      if (div_val >= MIN_DIV) begin
        div_pend_n = div_val;
        pend_v_n   = 1'b1;
      end else begin
        load_err_n = 1'b1;
      end
    end

    tick_n = (state_n == RUNNING) && (cnt_n == '0);
  end

  assign div_cur = div_act;

  clk_div_neg_stage u_neg_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .p       (p),
    .odd     (div_act[0]),
    .clk_out (clk_out)
  );

endmodule

// File: tb/tb_clk_div_n.sv
// tb/tb_clk_div_n.sv - randomized bench for clk_div_n against a period-level reference model
module tb_clk_div_n;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] div_val;
  logic       div_load;
  logic       clk_out;
  logic       tick;
  logic [7:0] div_cur;
  logic       load_err;

  int total = 0;
  int bad   = 0;
  bit chk_on;

  // reference model: position within the output period and divisor bookkeeping
  bit m_run;
  int m_k;
  int m_n;
  int m_pend;
  bit m_pend_v;
  bit m_err;

  clk_div_n #(.CNT_W(8), .DIV_RST(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_cur  (div_cur),
    .load_err (load_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run    = 1'b0;
    m_k      = 0;
    m_n      = 3;
    m_pend   = 3;
    m_pend_v = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_step();
    bit err_next;
    err_next = div_load && (int'(div_val) < 2);
    if (m_run) begin
      m_k++;
      if (m_k == m_n) begin
        if (m_pend_v) begin
          m_n      = m_pend;
          m_pend_v = 1'b0;
        end
        if (en) m_k = 0;
        else    m_run = 1'b0;
      end
    end else begin
      if (m_pend_v) begin
        m_n      = m_pend;
        m_pend_v = 1'b0;
      end
      if (en) begin
        m_run = 1'b1;
        m_k   = 0;
      end
    end
    if (div_load && int'(div_val) >= 2) begin
      m_pend   = int'(div_val);
      m_pend_v = 1'b1;
    end
    m_err = err_next;
  endtask

  // output is high for the first N of the 2N half-cycles of each period
  function automatic int exp_clk(input int half_idx);
    return (m_run && half_idx < m_n) ? 1 : 0;
  endfunction

  initial begin : compare
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      #1;
      if (chk_on) begin
        check("clk_out_pos", clk_out, exp_clk(2 * m_k));
        check("tick", tick, (m_run && m_k == 0) ? 1 : 0);
        check("div_cur", div_cur, m_n);
        check("load_err", load_err, m_err);
      end
      @(negedge clk);
      #1;
      if (chk_on) check("clk_out_neg", clk_out, rst_n ? exp_clk(2 * m_k + 1) : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic load(input int v);
    div_load = 1'b1;
    div_val  = 8'(v);
    cyc(1);
    div_load = 1'b0;
  endtask

  task automatic wait_tick(input string nm);
    int g;
    g = 0;
    do begin
      @(posedge clk);
      #1;
      g++;
    end while (!tick && g < 64);
    if (!tick) check({nm, "_tick_timeout"}, 0, 1);
  endtask

  task automatic measure(input string nm, input bit at_tick, input int exp_per, input int exp_hi);
    int per;
    int hi;
    if (!at_tick) wait_tick(nm);
    per = 0;
    hi  = 0;
    do begin
      if (clk_out) hi++;
      @(negedge clk);
      #1;
      if (clk_out) hi++;
      @(posedge clk);
      #1;
      per++;
    end while (!tick && per < 64);
    check({nm, "_period"}, per, exp_per);
    check({nm, "_high_halves"}, hi, exp_hi);
  endtask

  initial begin : main
    int nt;
    rst_n    = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    div_val  = '0;
    chk_on   = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("rst_clk_out", clk_out, 0);
    check("rst_tick", tick, 0);
    check("rst_div_cur", div_cur, 3);
    check("rst_load_err", load_err, 0);
    chk_on = 1'b1;
    cyc(2);

    en = 1'b1;
    @(posedge clk);
    #1;
    check("en_rise_clk", clk_out, 1);
    check("en_rise_tick", tick, 1);
    measure("n3", 1'b1, 3, 3);

    cyc(1);
    load(4);
    cyc(8);
    measure("n4", 1'b0, 4, 4);
    check("n4_div_cur", div_cur, 4);

    cyc(1);
    load(7);
    cyc(10);
    measure("n7", 1'b0, 7, 7);
    cyc(1);
    load(1);
    check("bad_load_err", load_err, 1);
    cyc(9);
    check("bad_load_div_cur", div_cur, 7);

    load(5);
    cyc(10);
    wait_tick("dis");
    repeat (2) @(posedge clk);
    #2;
    en = 1'b0;
    nt = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (tick) nt++;
    end
    check("parked_ticks", nt, 0);
    check("parked_clk_out", clk_out, 0);
    #2;
    en = 1'b1;
    @(posedge clk);
    #1;
    check("reen_rise", clk_out, 1);

    cyc(1);
    en = 1'b0;
    cyc(12);
    div_load = 1'b1;
    div_val  = 8'd6;
    cyc(1);
    div_val  = 8'd9;
    cyc(1);
    div_load = 1'b0;
    cyc(1);
    check("parked_last_wins", div_cur, 9);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("n9_first_tick", tick, 1);
    measure("n9", 1'b1, 9, 9);

    cyc(1);
    load(5);
    cyc(12);
    wait_tick("rst");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_clk_out", clk_out, 0);
    check("rst_mid_div_cur", div_cur, 3);
    cyc(1);
    rst_n = 1'b1;
    #1;
    check("rst_rel_clk_out", clk_out, 0);
    @(posedge clk);
    #1;
    check("rst_rel_rise", clk_out, 1);
    measure("rst_n3", 1'b1, 3, 3);

    cyc(1);
    for (int i = 0; i < 3000; i++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 24) == 0) en = ~en;
      div_load = ($urandom_range(0, 9) == 0);
      div_val  = 8'($urandom_range(0, 11));
      cyc(1);
    end
    div_load = 1'b0;
    rst_n    = 1'b1;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
